// File: rtl/pad_pkg.sv
// Shared NES/SNES pad definitions: button indices, frame lengths and FSM encoding.
// The receiver imports this package too, so the bit order lives in one place.
package pad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_X      = 8;
  localparam int BTN_Y      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int NES_FRAME_BITS  = 8;
  localparam int SNES_FRAME_BITS = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/pad_controller_emulator_if.sv
// Host-side pad pins: latch and clock from the host, serial data back to it.
interface pad_controller_emulator_if;
  logic pad_latch;
  logic pad_clk;
  logic pad_data;

  modport master (output pad_latch, output pad_clk, input pad_data);
  modport slave  (input pad_latch, input pad_clk, output pad_data);
endinterface

// File: rtl/pad_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a history flop
// that yields single-cycle rise/fall strobes in the system clock domain.
module pad_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/pad_controller_emulator.sv
// Device-side NES/SNES pad: captures buttons on latch, shifts them out
// active-low on each host clock rising edge.
module pad_controller_emulator
  import pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                      system_clk_25MHz,
  input  logic                      rst_n,
  input  logic                      snes_mode,
  input  logic [11:0]               buttons,
  pad_controller_emulator_if.slave  pad,
  output logic                      frame_done,
  output logic                      busy
);

  logic        lat_rise, lat_fall, clk_rise, clk_fall_unused;
  logic [1:0]  state;
  logic [15:0] sr, load;
  logic        mode;
  logic [4:0]  bit_cnt, frame_len;

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lat_sync (
    .clk(system_clk_25MHz), .rst_n(rst_n), .pin(pad.pad_latch),
    .rise(lat_rise), .fall(lat_fall)
  );

  // pad_clk idles high, so its synchronizer resets high to avoid a false edge
  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
    .clk(system_clk_25MHz), .rst_n(rst_n), .pin(pad.pad_clk),
    .rise(clk_rise), .fall(clk_fall_unused)
  );

  always_comb begin
    if (snes_mode)
      load = {4'hF,
              ~buttons[BTN_R], ~buttons[BTN_L], ~buttons[BTN_X], ~buttons[BTN_A],
              ~buttons[BTN_RIGHT], ~buttons[BTN_LEFT], ~buttons[BTN_DOWN], ~buttons[BTN_UP],
              ~buttons[BTN_START], ~buttons[BTN_SELECT], ~buttons[BTN_Y], ~buttons[BTN_B]};
    else
      load = {8'hFF,
              ~buttons[BTN_RIGHT], ~buttons[BTN_LEFT], ~buttons[BTN_DOWN], ~buttons[BTN_UP],
              ~buttons[BTN_START], ~buttons[BTN_SELECT], ~buttons[BTN_B], ~buttons[BTN_A]};
  end

  assign frame_len = mode ? 5'(SNES_FRAME_BITS) : 5'(NES_FRAME_BITS);
  assign busy      = (state == ST_LATCH) || (state == ST_SHIFT);

  always_ff @(posedge system_clk_25MHz) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sr           <= '1;
      mode         <= 1'b0;
      bit_cnt      <= '0;
      pad.pad_data <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (lat_rise) begin
            state        <= ST_LATCH;
            sr           <= load;
            mode         <= snes_mode;
            pad.pad_data <= load[0];
          end else begin
            pad.pad_data <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (lat_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end else begin
            sr           <= load;
            mode         <= snes_mode;
            pad.pad_data <= load[0];
          end
        end
        ST_SHIFT: begin
          // a new latch aborts the frame and takes priority over a clock edge
          if (lat_rise) begin
            state        <= ST_LATCH;
            sr           <= load;
            mode         <= snes_mode;
            pad.pad_data <= load[0];
          end else if (bit_cnt == frame_len) begin
            state        <= ST_DONE;
            frame_done   <= 1'b1;
            pad.pad_data <= 1'b1;
          end else if (clk_rise) begin
            sr           <= {1'b1, sr[15:1]};
            pad.pad_data <= sr[1];
            bit_cnt      <= bit_cnt + 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_controller_emulator.sv
// Scoreboard bench: the host model pushes expected serial bits, a monitor
// pops and compares them whenever the host samples pad_data.
module tb_pad_controller_emulator;

  localparam int H = 8;  // host half-period in system clocks
  localparam int SNES_ORD [12] = '{1, 9, 2, 3, 4, 5, 6, 7, 0, 8, 10, 11};

  logic        system_clk_25MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        snes_mode = 1'b0;
  logic [11:0] buttons = '0;
  logic        frame_done, busy;
  logic        smp = 1'b0;
  logic        fd_prev = 1'b0;
  int          checks = 0, errors = 0, fd_cnt = 0;
  bit          exp_q[$];

  pad_controller_emulator_if pif ();

  pad_controller_emulator #(.SYNC_STAGES(2)) dut (
    .system_clk_25MHz(system_clk_25MHz),
    .rst_n(rst_n),
    .snes_mode(snes_mode),
    .buttons(buttons),
    .pad(pif.slave),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #20 system_clk_25MHz = ~system_clk_25MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_bit(input logic [11:0] b, input bit snes, input int i);
    if (snes) return (i < 12) ? ~b[SNES_ORD[i]] : 1'b1;
    return (i < 8) ? ~b[i] : 1'b1;
  endfunction

  // scoreboard monitor: one comparison per host sample strobe
  always @(posedge smp) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL serial_bit: got %0b expected nothing (queue empty)", pif.pad_data);
    end else begin
      check("serial_bit", {31'b0, pif.pad_data}, {31'b0, exp_q.pop_front()});
    end
  end

  always @(negedge system_clk_25MHz) begin
    if (frame_done) fd_cnt++;
    if (frame_done && fd_prev) begin
      checks++;
      errors++;
      $display("FAIL frame_done_width: got 2+ cycles expected 1");
    end
    fd_prev = frame_done;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge system_clk_25MHz);
  endtask

  task automatic sample(input bit e);
    exp_q.push_back(e);
    smp = 1'b1;
    cyc(1);
    smp = 1'b0;
  endtask

  task automatic latch_pulse(input logic [11:0] b, input bit snes);
    buttons       = b;
    snes_mode     = snes;
    pif.pad_latch = 1'b1;
    cyc(H);
    pif.pad_latch = 1'b0;
    cyc(H);
  endtask

  // n host clocks; samples before each rise and once after the last one
  task automatic run_clocks(input logic [11:0] b, input bit snes, input int n, input bit dead);
    for (int i = 0; i <= n; i++) begin
      sample(dead ? 1'b1 : exp_bit(b, snes, i));
      if (i < n) begin
        pif.pad_clk = 1'b0;
        cyc(H);
        pif.pad_clk = 1'b1;
        cyc(H);
      end
    end
  endtask

  task automatic full_frame(input logic [11:0] b, input bit snes, input int extra, input string name);
    int fd0;
    fd0 = fd_cnt;
    latch_pulse(b, snes);
    check({name, "_busy"}, {31'b0, busy}, 32'd1);
    run_clocks(b, snes, (snes ? 16 : 8) + extra, 1'b0);
    cyc(4);
    check({name, "_done"}, fd_cnt - fd0, 32'd1);
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int fd0;
    logic [11:0] rb;
    bit rm;
    pif.pad_latch = 1'b0;
    pif.pad_clk   = 1'b1;
    cyc(3);
    check("rst_pad_data", {31'b0, pif.pad_data}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    full_frame(12'h001, 1'b1, 0, "snes_a");
    full_frame(12'h0F0, 1'b0, 3, "nes_dpad");

    // buttons and mode change after latch fall must not reach this frame
    fd0 = fd_cnt;
    latch_pulse(12'h0A5, 1'b1);
    buttons   = 12'hFFF;
    snes_mode = 1'b0;
    run_clocks(12'h0A5, 1'b1, 16, 1'b0);
    cyc(4);
    check("hold_done", fd_cnt - fd0, 32'd1);
    full_frame(12'hFFF, 1'b1, 0, "new_capture");

    // latch mid-frame aborts without frame_done and restarts at bit 0
    fd0 = fd_cnt;
    latch_pulse(12'h123, 1'b1);
    run_clocks(12'h123, 1'b1, 5, 1'b0);
    latch_pulse(12'h456, 1'b1);
    check("abort_no_done", fd_cnt - fd0, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd1);
    run_clocks(12'h456, 1'b1, 16, 1'b0);
    cyc(4);
    check("restart_done", fd_cnt - fd0, 32'd1);

    // reset in the middle of SHIFT drops the frame
    fd0 = fd_cnt;
    latch_pulse(12'hFFF, 1'b1);
    run_clocks(12'hFFF, 1'b1, 3, 1'b0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("midrst_pad_data", {31'b0, pif.pad_data}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    run_clocks(12'hFFF, 1'b1, 6, 1'b1);
    cyc(4);
    check("midrst_no_done", fd_cnt - fd0, 32'd0);
    check("midrst_still_idle", {31'b0, busy}, 32'd0);

    // back-to-back frames with random vectors
    for (int k = 0; k < 20; k++) begin
      rb = 12'($urandom);
      rm = 1'($urandom_range(0, 1));
      full_frame(rb, rm, 0, "random");
    end

    cyc(5);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_controller_emulator.md
# pad_controller_emulator

Device-side model of the NES/SNES serial controller protocol. The block receives latch and clock from a host, captures a parallel button vector, and shifts it out serially on the data line, exactly as a physical pad does. It sits on the FPGA test harness opposite the NES/SNES receiver. It lets the receiver and game logic be exercised without a real pad, from switches or a scripted stimulus source.

## Interface
- SYNC_STAGES, 2, synchronizer depth for the latch and clock pins (minimum 2).
- system_clk_25MHz  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; clock system_clk_25MHz.
- snes_mode  in  1  1 = 16-bit SNES frame, 0 = 8-bit NES frame; sampled only at latch capture.
- buttons  in  12  active-high pressed flags: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]X [9]Y [10]L [11]R.
- pad_latch  in  1  host latch pin, asynchronous.
- pad_clk  in  1  host clock pin, asynchronous, idles high.
- pad_data  out  1  serial data to host; active-low (0 = pressed).
- frame_done  out  1  one-cycle pulse when the last frame bit has been consumed.
- busy  out  1  high from latch capture until frame_done or restart.

## Operation
- Both pins pass through SYNC_STAGES flops, then one history flop. Edges are detected on the synchronized signals only.
- Frame order and length:
  - SNES order: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then four constant 1s (bits 12–15).
  - NES order: A, B, Select, Start, Up, Down, Left, Right.
- Shift register: 16 bits, holding the inverted buttons in frame order. In NES mode, bits 8–15 load as 1.
- FSM states:
  - IDLE: pad_data = 1, busy = 0. A synchronized latch high moves to LATCH.
  - LATCH: reload the shift register and mode every cycle while latch is high. pad_data = bit 0 and busy = 1. Latch falling moves to SHIFT with bit_cnt = 0.
  - SHIFT: on each synchronized pad_clk rising edge, shift right, fill with 1, and increment bit_cnt. When bit_cnt reaches the frame length (8 or 16), pulse frame_done and go to DONE.
  - DONE: pad_data = 1, busy = 0. Further clock edges are ignored. Latch high moves to LATCH.
- pad_data is registered and always equals shift register bit 0 in LATCH and SHIFT.
- Latch rising while in SHIFT: abort the frame immediately, enter LATCH, and issue no frame_done.
- Latch and clock edges in the same cycle: the latch wins and the clock edge is discarded.
- Clock edges in IDLE or LATCH are ignored.
- Changes to buttons or snes_mode after the latch falls do not affect the current frame.

## Timing
- Reset values: pad_data = 1, frame_done = 0, busy = 0, FSM = IDLE, bit_cnt = 0, shift register all 1s.
- Pin-to-output latency: SYNC_STAGES + 1 cycles from a pin edge to the pad_data update. This is 3 cycles (120 ns) at default, well inside the 6 µs host half-period.
- The first bit is valid on pad_data 1 cycle after the synchronized latch goes high.
- frame_done is asserted in the cycle after the final shift is registered, and lasts exactly 1 cycle.
- Reset asserted mid-frame: all state returns to reset values on the next clock edge. The rest of that frame is dropped silently.
- Minimum pin pulse width guaranteed to be seen: 2 clock periods (80 ns).

## Structure
- The shared package pad_pkg holds:
  - button index localparams (BTN_A … BTN_R);
  - NES_FRAME_BITS = 8 and SNES_FRAME_BITS = 16;
  - the FSM state encoding.
- The receiver imports the same package, so bit order is defined in one place.
- One sub-module: pad_sync_edge (synchronizer plus rise/fall detector, parameter SYNC_STAGES), instantiated twice.
- The frame-ordering mux and FSM stay in the top module.

## Test plan
- SNES, buttons = 12'h001 (A only), full 16-clock frame → serial stream 1,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1; frame_done pulses once after clock 16.
- NES mode, buttons = 12'h0F0 (all d-pad), 8 clocks → 1,1,1,1,0,0,0,0; frame_done after clock 8; extra clocks keep pad_data = 1.
- Buttons toggled to 12'hFFF after latch fall, mid-frame → the current frame still matches the pre-latch value; the next latch picks up the new value.
- Latch reasserted after 5 SNES clocks → no frame_done; the new frame restarts at bit 0 with a fresh capture.
- rst_n low for 1 cycle in the middle of SHIFT → pad_data = 1, busy = 0 on the next edge; subsequent clocks are ignored until a latch arrives.
- Back-to-back frames at the real host rate (12 µs latch, 6 µs half-period) driven against the NES/SNES receiver → the receiver outputs match buttons for 100 random vectors.
